// File: rtl/replica_sequencer.sv
// replica_sequencer: per-iteration phase controller for the replica-exchange
// node array. Each iteration runs opt sweep -> exp evaluation -> distance
// shift -> ordering shift. All outputs are registered from the next state,
// so each phase strobe is high exactly for the cycles spent in its state.
module replica_sequencer #(
    parameter int BASE_NUM     = 8,
    parameter int BASE_LOG     = 3,
    parameter int EXP_CYCLES   = 17,
    parameter int SHIFT_CYCLES = 32,
    parameter int TW_LAG       = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [31:0]         i_iter_num,
    input  logic [15:0]         i_opt_sweep,
    input  logic                i_or_en,
    input  logic                i_tw_en,
    input  logic                i_random_ready,
    output logic                o_opt_run,
    output logic                o_or_opt_en,
    output logic                o_tw_opt_en,
    output logic [BASE_LOG-1:0] o_or_rn_base_id,
    output logic [BASE_LOG-1:0] o_or_dd_base_id,
    output logic [BASE_LOG-1:0] o_or_rp_base_id,
    output logic [BASE_LOG-1:0] o_or_ex_base_id,
    output logic [BASE_LOG-1:0] o_tw_rn_base_id,
    output logic [BASE_LOG-1:0] o_tw_dd_base_id,
    output logic [BASE_LOG-1:0] o_tw_rp_base_id,
    output logic [BASE_LOG-1:0] o_tw_ex_base_id,
    output logic                o_exp_init,
    output logic                o_exp_run,
    output logic                o_exp_fin,
    output logic                o_distance_shift,
    output logic                o_exchange_shift_d,
    output logic                o_busy,
    output logic                o_done,
    output logic [31:0]         o_iter_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RDY, S_OPT, S_EXP_INIT, S_EXP_RUN,
        S_EXP_FIN, S_DSHIFT, S_XSHIFT, S_NEXT
    } state_t;

    localparam logic [BASE_LOG-1:0] LAST = BASE_LOG'(BASE_NUM - 1);
    localparam logic [BASE_LOG-1:0] ONE  = BASE_LOG'(1);

    // Modulo-BASE_NUM subtract by repeated wrap-decrement; works for any
    // BASE_NUM, not just powers of two, and for k >= BASE_NUM.
    function automatic logic [BASE_LOG-1:0] sub_mod(input logic [BASE_LOG-1:0] x, input int k);
        logic [BASE_LOG-1:0] v;
        v = x;
        for (int i = 0; i < k; i++) v = (v == '0) ? LAST : v - ONE;
        return v;
    endfunction

    state_t              r_state, w_state_next;
    logic [15:0]         r_cyc;
    logic [15:0]         w_opt_len;
    logic [BASE_LOG-1:0] r_cnt, w_cnt_next;
    logic                r_abort;
    logic                w_end;
    logic [31:0]         r_iter_count, w_iter_next;
    logic                r_opt_run, r_or_opt_en, r_tw_opt_en;
    logic                r_exp_init, r_exp_run, r_exp_fin, r_dshift, r_xshift;
    logic                r_busy, r_done, w_done;
    logic [BASE_LOG-1:0] r_or_rn, r_or_dd, r_or_rp, r_or_ex;
    logic [BASE_LOG-1:0] r_tw_rn, r_tw_dd, r_tw_rp, r_tw_ex;

    assign w_opt_len = (i_opt_sweep == 16'd0) ? 16'd1 : i_opt_sweep;
    // Run ends when this iteration is the last one or an abort is pending.
    assign w_end     = (r_iter_count + 32'd1 == i_iter_num) || r_abort || i_abort;

    // State register, per-state cycle counter and abort latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cyc   <= 16'd0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cyc   <= (w_state_next != r_state) ? 16'd0 : r_cyc + 16'd1;
            if (r_state == S_IDLE) r_abort <= 1'b0;
            else if (i_abort)      r_abort <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_state_next = (i_iter_num == 32'd0) ? S_NEXT : S_WAIT_RDY;
            S_WAIT_RDY: if (i_random_ready) w_state_next = S_OPT;
            S_OPT:      if (r_cyc == w_opt_len - 16'd1) w_state_next = S_EXP_INIT;
            S_EXP_INIT: w_state_next = S_EXP_RUN;
            S_EXP_RUN:  if (r_cyc == 16'(EXP_CYCLES - 1)) w_state_next = S_EXP_FIN;
            S_EXP_FIN:  w_state_next = S_DSHIFT;
            S_DSHIFT:   if (r_cyc == 16'(SHIFT_CYCLES - 1)) w_state_next = S_XSHIFT;
            S_XSHIFT:   if (r_cyc == 16'(SHIFT_CYCLES - 1)) w_state_next = S_NEXT;
            S_NEXT:     w_state_next = r_done ? S_IDLE : S_WAIT_RDY;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_iter_next = r_iter_count;
        if (r_state == S_IDLE && i_start) begin
            w_cnt_next  = '0;
            w_iter_next = 32'd0;
        end else if (w_state_next == S_OPT) begin
            w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + ONE;
        end else if (r_state == S_XSHIFT && w_state_next == S_NEXT) begin
            w_iter_next = r_iter_count + 32'd1;
        end
        // iter_num == 0 reaches NEXT straight from IDLE and always ends there.
        w_done = (w_state_next == S_NEXT) && ((r_state == S_IDLE) || w_end);
    end

    // Output and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_iter_count <= 32'd0;
            r_opt_run    <= 1'b0;
            r_or_opt_en  <= 1'b0;
            r_tw_opt_en  <= 1'b0;
            r_exp_init   <= 1'b0;
            r_exp_run    <= 1'b0;
            r_exp_fin    <= 1'b0;
            r_dshift     <= 1'b0;
            r_xshift     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_or_rn      <= '0;
            r_or_dd      <= '0;
            r_or_rp      <= '0;
            r_or_ex      <= '0;
            r_tw_rn      <= '0;
            r_tw_dd      <= '0;
            r_tw_rp      <= '0;
            r_tw_ex      <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_iter_count <= w_iter_next;
            r_opt_run    <= (w_state_next == S_OPT);
            r_or_opt_en  <= (w_state_next == S_OPT) && i_or_en;
            r_tw_opt_en  <= (w_state_next == S_OPT) && i_tw_en;
            r_exp_init   <= (w_state_next == S_EXP_INIT);
            r_exp_run    <= (w_state_next == S_EXP_RUN);
            r_exp_fin    <= (w_state_next == S_EXP_FIN);
            r_dshift     <= (w_state_next == S_DSHIFT);
            r_xshift     <= (w_state_next == S_XSHIFT);
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= w_done;
            // Base IDs only move with the rotation, i.e. on OPT cycles.
            if (w_state_next == S_OPT) begin
                r_or_rn <= w_cnt_next;
                r_or_dd <= sub_mod(w_cnt_next, 1);
                r_or_rp <= sub_mod(w_cnt_next, 2);
                r_or_ex <= sub_mod(w_cnt_next, 3);
                r_tw_rn <= sub_mod(w_cnt_next, TW_LAG);
                r_tw_dd <= sub_mod(w_cnt_next, 1 + TW_LAG);
                r_tw_rp <= sub_mod(w_cnt_next, 2 + TW_LAG);
                r_tw_ex <= sub_mod(w_cnt_next, 3 + TW_LAG);
            end
        end
    end

    assign o_opt_run          = r_opt_run;
    assign o_or_opt_en        = r_or_opt_en;
    assign o_tw_opt_en        = r_tw_opt_en;
    assign o_or_rn_base_id    = r_or_rn;
    assign o_or_dd_base_id    = r_or_dd;
    assign o_or_rp_base_id    = r_or_rp;
    assign o_or_ex_base_id    = r_or_ex;
    assign o_tw_rn_base_id    = r_tw_rn;
    assign o_tw_dd_base_id    = r_tw_dd;
    assign o_tw_rp_base_id    = r_tw_rp;
    assign o_tw_ex_base_id    = r_tw_ex;
    assign o_exp_init         = r_exp_init;
    assign o_exp_run          = r_exp_run;
    assign o_exp_fin          = r_exp_fin;
    assign o_distance_shift   = r_dshift;
    assign o_exchange_shift_d = r_xshift;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_iter_count       = r_iter_count;

endmodule

// File: tb/tb_replica_sequencer.sv
// Directed bench for replica_sequencer: a table of whole-run vectors plus
// hand-written sequences for rotation, ready stall, abort, reset and enables.
module tb_replica_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, or_en, tw_en, random_ready;
    logic [31:0] iter_num;
    logic [15:0] opt_sweep;
    logic        opt_run, or_opt_en, tw_opt_en;
    logic [2:0]  or_rn, or_dd, or_rp, or_ex, tw_rn, tw_dd, tw_rp, tw_ex;
    logic        exp_init, exp_run, exp_fin, dshift, xshift, busy, done;
    logic [31:0] iter_count;

    replica_sequencer #(.BASE_NUM(8), .BASE_LOG(3), .EXP_CYCLES(17), .SHIFT_CYCLES(32), .TW_LAG(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_iter_num(iter_num), .i_opt_sweep(opt_sweep), .i_or_en(or_en), .i_tw_en(tw_en),
        .i_random_ready(random_ready),
        .o_opt_run(opt_run), .o_or_opt_en(or_opt_en), .o_tw_opt_en(tw_opt_en),
        .o_or_rn_base_id(or_rn), .o_or_dd_base_id(or_dd), .o_or_rp_base_id(or_rp), .o_or_ex_base_id(or_ex),
        .o_tw_rn_base_id(tw_rn), .o_tw_dd_base_id(tw_dd), .o_tw_rp_base_id(tw_rp), .o_tw_ex_base_id(tw_ex),
        .o_exp_init(exp_init), .o_exp_run(exp_run), .o_exp_fin(exp_fin),
        .o_distance_shift(dshift), .o_exchange_shift_d(xshift),
        .o_busy(busy), .o_done(done), .o_iter_count(iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] iter_num;
        logic [15:0] opt_sweep;
        logic        or_en, tw_en;
        int          e_opt, e_init, e_run, e_fin, e_ds, e_xs, e_busy, e_or, e_tw, e_iter;
    } vec_t;

    int n_chk = 0, n_err = 0;
    int c_opt, c_init, c_run, c_fin, c_ds, c_xs, c_busy, c_done, c_or, c_tw, c_excl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        {c_opt, c_init, c_run, c_fin, c_ds, c_xs, c_busy, c_done, c_or, c_tw, c_excl} = '0;
    endtask

    function automatic logic any_out();
        return |{opt_run, or_opt_en, tw_opt_en, or_rn, or_dd, or_rp, or_ex, tw_rn, tw_dd, tw_rp, tw_ex,
                 exp_init, exp_run, exp_fin, dshift, xshift, busy, done, iter_count};
    endfunction

    function automatic logic any_phase();
        return |{opt_run, or_opt_en, tw_opt_en, exp_init, exp_run, exp_fin, dshift, xshift};
    endfunction

    // Accumulate per-cycle activity and flag exclusivity violations.
    task automatic sample();
        c_opt  += int'(opt_run);
        c_init += int'(exp_init);
        c_run  += int'(exp_run);
        c_fin  += int'(exp_fin);
        c_ds   += int'(dshift);
        c_xs   += int'(xshift);
        c_busy += int'(busy);
        c_done += int'(done);
        c_or   += int'(or_opt_en);
        c_tw   += int'(tw_opt_en);
        if ($countones({opt_run, exp_init, exp_run, exp_fin, dshift, xshift}) > 1) c_excl++;
        if ((or_opt_en || tw_opt_en) && !opt_run) c_excl++;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until busy drops, with a cycle budget.
    task automatic run_to_idle(input string name, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            sample();
            if (!busy) break;
            tick();
        end
        chk({name, "_timeout"}, 32'(k >= bound), 32'd0);
    endtask

    vec_t vt[4];
    int   q[$];
    logic tw_at_edge;
    int   bad;

    initial begin
        // iter, sweep, or, tw, opt, init, run, fin, ds, xs, busy, or, tw, iter
        vt[0] = '{32'd1, 16'd4, 1'b1, 1'b1, 4, 1, 17, 1, 32, 32, 89, 4, 4, 1};
        vt[1] = '{32'd2, 16'd0, 1'b1, 1'b0, 2, 2, 34, 2, 64, 64, 172, 2, 0, 2};
        vt[2] = '{32'd3, 16'd3, 1'b0, 1'b0, 9, 3, 51, 3, 96, 96, 264, 0, 0, 3};
        vt[3] = '{32'd0, 16'd5, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

        random_ready = 1'b1; iter_num = 32'd1; opt_sweep = 16'd4; or_en = 1'b0; tw_en = 1'b0;
        do_reset();
        chk("reset_outputs", 32'(any_out()), 32'd0);

        // Table of whole-run vectors.
        foreach (vt[i]) begin
            do_reset();
            iter_num = vt[i].iter_num; opt_sweep = vt[i].opt_sweep;
            or_en = vt[i].or_en; tw_en = vt[i].tw_en;
            clr_counts();
            pulse_start();
            run_to_idle($sformatf("v%0d", i), 2000);
            chk($sformatf("v%0d_opt", i),  c_opt,  vt[i].e_opt);
            chk($sformatf("v%0d_init", i), c_init, vt[i].e_init);
            chk($sformatf("v%0d_run", i),  c_run,  vt[i].e_run);
            chk($sformatf("v%0d_fin", i),  c_fin,  vt[i].e_fin);
            chk($sformatf("v%0d_ds", i),   c_ds,   vt[i].e_ds);
            chk($sformatf("v%0d_xs", i),   c_xs,   vt[i].e_xs);
            chk($sformatf("v%0d_busy", i), c_busy, vt[i].e_busy);
            chk($sformatf("v%0d_or", i),   c_or,   vt[i].e_or);
            chk($sformatf("v%0d_tw", i),   c_tw,   vt[i].e_tw);
            chk($sformatf("v%0d_done", i), c_done, 1);
            chk($sformatf("v%0d_excl", i), c_excl, 0);
            chk($sformatf("v%0d_iter", i), iter_count, vt[i].e_iter);
        end

        // Base ID rotation across two iterations of 10 OPT cycles.
        do_reset();
        iter_num = 32'd2; opt_sweep = 16'd10; or_en = 1'b1; tw_en = 1'b1;
        q.delete();
        pulse_start();
        for (int k = 0; k < 1000 && busy; k++) begin
            if (opt_run) begin
                if (q.size() == 0) begin
                    chk("rot_first_rn", or_rn, 1);
                    chk("rot_dd", or_dd, 0);
                    chk("rot_rp", or_rp, 7);
                    chk("rot_ex", or_ex, 6);
                    chk("rot_tw_rn", tw_rn, 0);
                    chk("rot_tw_ex", tw_ex, 5);
                end
                q.push_back(int'(or_rn));
            end
            tick();
        end
        chk("rot_count", q.size(), 20);
        chk("rot_iter2_start", (q.size() > 10) ? q[10] : -1, 3);
        bad = 0;
        foreach (q[i]) if (q[i] != (i + 1) % 8) bad++;
        chk("rot_sequence", bad, 0);
        chk("rot_hold_idle", or_rn, 4);

        // random_ready stall: 20 cycles in WAIT_RDY.
        do_reset();
        iter_num = 32'd1; opt_sweep = 16'd1; random_ready = 1'b0;
        pulse_start();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy || any_phase()) bad++;
            tick();
        end
        chk("stall_idle_outputs", bad, 0);
        random_ready = 1'b1;
        chk("stall_opt_before", opt_run, 0);
        tick();
        chk("stall_opt_rise", opt_run, 1);
        clr_counts();
        run_to_idle("stall", 500);

        // Abort mid EXP_RUN of iteration 2; stray start ignored.
        do_reset();
        iter_num = 32'd5; opt_sweep = 16'd2;
        clr_counts();
        pulse_start();
        begin
            int  k;
            bit  aborted;
            aborted = 1'b0;
            for (k = 0; k < 3000; k++) begin
                sample();
                if (!busy) break;
                abort = 1'b0;
                start = (k == 30);
                if (c_init == 2 && exp_run && c_run == 25 && !aborted) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end
                tick();
            end
            abort = 1'b0; start = 1'b0;
            chk("abort_timeout", 32'(k >= 3000), 0);
            chk("abort_sent", 32'(aborted), 1);
        end
        chk("abort_done", c_done, 1);
        chk("abort_iter", iter_count, 2);
        chk("abort_xs_full", c_xs, 64);
        chk("abort_init", c_init, 2);

        // Synchronous reset in DSHIFT, then an iter_num=0 run.
        do_reset();
        iter_num = 32'd1; opt_sweep = 16'd1;
        pulse_start();
        for (int k = 0; k < 200 && !dshift; k++) tick();
        chk("rst_reached_ds", dshift, 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_outputs", 32'(any_out()), 0);
        reset = 1'b0;
        tick();
        chk("rst_no_done", {busy, done}, 0);
        iter_num = 32'd0;
        pulse_start();
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_phase", 32'(any_phase()), 0);
        tick();
        chk("zero_end", {busy, done}, 0);
        chk("zero_iter", iter_count, 0);

        // tw_en toggled during OPT: tw_opt_en lags it by one cycle, gated by opt_run.
        do_reset();
        iter_num = 32'd1; opt_sweep = 16'd8; or_en = 1'b1; tw_en = 1'b1;
        tw_at_edge = tw_en;
        clr_counts();
        pulse_start();
        bad = 0;
        for (int k = 0; k < 500 && busy; k++) begin
            sample();
            if (tw_opt_en !== (opt_run && tw_at_edge)) bad++;
            if (or_opt_en !== opt_run) bad++;
            tw_en = (k % 3 == 1);
            tw_at_edge = tw_en;
            tick();
        end
        chk("twen_follow", bad, 0);
        chk("twen_opt", c_opt, 8);
        chk("twen_excl", c_excl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
